disp_scan_ctrl: RTL

- Time-multiplexing scan controller for the two-digit action/speed 7-segment display.
- Drives the select input of the downstream 2:1 segment mux: sel=0 shows the action digit, sel=1 shows the speed digit.
- Drives the matching digit anode enables, with a blanking gap at each digit change to prevent ghosting.
- Optional blinking of the speed digit, plus a once-per-frame tick.

---
 rtl/disp_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Two-digit 7-segment scan controller: mux select, anodes with a blanking gap per slot,
// optional speed-digit blink and a once-per-frame tick. All outputs registered from next state.
module disp_scan_ctrl #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYC     = 500,
    parameter int BLINK_DIV     = 25,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blink_spd,
    output logic       sel,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic [1:0] AN_ACT = (AN_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
    localparam logic [1:0] AN_SPD = (AN_ACTIVE_LOW != 0) ? 2'b01 : 2'b10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BLANK_A = 3'd1;
    localparam logic [2:0] ST_SHOW_A  = 3'd2;
    localparam logic [2:0] ST_BLANK_S = 3'd3;
    localparam logic [2:0] ST_SHOW_S  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          frame_end;
    logic          sel_q, sel_d;
    logic [1:0]    an_q, an_d;
    logic          frame_tick_q, frame_tick_d;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        frame_end     = 1'b0;
        if (!en) begin
            state_d       = ST_IDLE;
            slot_d        = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else begin
            slot_d = slot_q + SW'(1);
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK_A;
                    slot_d  = '0;
                end
                ST_BLANK_A: if (slot_q == BLANK_LAST) state_d = ST_SHOW_A;
                ST_SHOW_A: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_BLANK_S;
                        slot_d  = '0;
                    end
                end
                ST_BLANK_S: if (slot_q == BLANK_LAST) state_d = ST_SHOW_S;
                ST_SHOW_S: begin
                    if (slot_q == SLOT_LAST) begin
                        state_d   = ST_BLANK_A;
                        slot_d    = '0;
                        frame_end = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end
            endcase
            // Blink state only advances while blinking is requested, so it restarts visible.
            if (!blink_spd) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
            end else if (frame_end) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BW'(1);
                end
            end
        end
    end

    always_comb begin
        sel_d        = 1'b0;
        an_d         = AN_OFF;
        frame_tick_d = 1'b0;
        case (state_d)
            ST_SHOW_A: an_d = AN_ACT;
            ST_BLANK_S: sel_d = 1'b1;
            ST_SHOW_S: begin
                sel_d        = 1'b1;
                an_d         = blink_phase_d ? AN_OFF : AN_SPD;
                frame_tick_d = (slot_d == SLOT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sel_q         <= 1'b0;
            an_q          <= AN_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            sel_q         <= sel_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
